// File: rtl/maxterm_extractor.sv
// maxterm_extractor
// Sweeps the three function inputs x/y/z through indices 0..7. Each index is
// held for SETTLE cycles before f_in is sampled. At the end of the sweep the
// maxterm list (F=0 indices), the minterm list (F=1 indices) and the maxterm
// count are published together.
//
// Build option: MAXTERM_COUNT_EN -- when defined, count is the number of
// maxterms. When undefined, no popcount logic is built and count reads 0.
//
// state | meaning
// IDLE  | waiting for start; x/y/z = 000
// WAIT  | driving index idx; settle counter runs down, f_in sampled at 1
// DONE  | one-cycle done pulse; results already updated
module maxterm_extractor #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       f_in,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic [7:0] maxterms,
  output logic [7:0] minterms,
  output logic [3:0] count
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [3:0] settle_cnt, settle_nxt;
  logic [7:0] shadow, shadow_nxt;
  logic       sample;
  logic       last;

  // Terminal count of the settle timer marks the sampling edge.
  assign sample = (state == WAIT) && (settle_cnt == 4'd1);
  assign last   = sample && (idx == 3'd7);

  // Inputs of the function under test are only driven during the sweep.
  assign x    = (state == WAIT) & idx[2];
  assign y    = (state == WAIT) & idx[1];
  assign z    = (state == WAIT) & idx[0];
  assign busy = (state == WAIT);
  assign done = (state == DONE);

  // State, index, settle timer and shadow register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      settle_cnt <= 4'd0;
      shadow     <= 8'd0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      settle_cnt <= settle_nxt;
      shadow     <= shadow_nxt;
    end
  end

  // Next-state logic: start/settle/sample sequencing.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    settle_nxt = settle_cnt;
    shadow_nxt = shadow;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = WAIT;
          idx_nxt    = 3'd0;
          settle_nxt = SETTLE_LD;
        end
      end
      WAIT: begin
        if (sample) begin
          shadow_nxt[idx] = ~f_in;
          if (idx == 3'd7) begin
            state_nxt  = DONE;
            idx_nxt    = 3'd0;
            settle_nxt = 4'd0;
          end else begin
            idx_nxt    = idx + 3'd1;
            settle_nxt = SETTLE_LD;
          end
        end else begin
          settle_nxt = settle_cnt - 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Published lists change only on the final sample, so they are never torn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      maxterms <= 8'd0;
      minterms <= 8'd0;
    end else if (last) begin
      maxterms <= shadow_nxt;
      minterms <= ~shadow_nxt;
    end
  end

`ifdef MAXTERM_COUNT_EN
  logic [3:0] pop_cnt;

  // Number of maxterms in the list about to be published.
  always_comb begin
    pop_cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      pop_cnt = pop_cnt + {3'd0, shadow_nxt[i]};
    end
  end

  // Count is registered alongside the lists.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 4'd0;
    end else if (last) begin
      count <= pop_cnt;
    end
  end
`else
  assign count = 4'd0;
`endif

endmodule

// File: tb/tb_maxterm_extractor.sv
// Scoreboard bench for maxterm_extractor: SETTLE=1 and SETTLE=3 instances.
// Each start pushes the expected lists, count and done cycle; monitors pop on done.
module tb_maxterm_extractor;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;

  typedef struct {
    logic [7:0] mt;
    logic [7:0] mn;
    logic [3:0] cnt;
    int         dcyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  logic       start1, start3;
  logic [7:0] tt1, tt3;
  logic       f_in1, f_in3;
  logic       x1, y1, z1, busy1, done1;
  logic       x3, y3, z3, busy3, done3;
  logic [7:0] maxterms1, minterms1, maxterms3, minterms3;
  logic [3:0] count1, count3;

  assign f_in1 = tt1[{x1, y1, z1}];
  assign f_in3 = tt3[{x3, y3, z3}];

  maxterm_extractor #(.SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .f_in(f_in1),
    .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1),
    .maxterms(maxterms1), .minterms(minterms1), .count(count1)
  );

  maxterm_extractor #(.SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .f_in(f_in3),
    .x(x3), .y(y3), .z(z3), .busy(busy3), .done(done3),
    .maxterms(maxterms3), .minterms(minterms3), .count(count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic exp_t mk(input logic [7:0] mt, input logic [7:0] mn,
                              input logic [3:0] cnt, input int dcyc);
    exp_t e;
    e.mt = mt;
    e.mn = mn;
`ifdef MAXTERM_COUNT_EN
    e.cnt = cnt;
`else
    e.cnt = 4'd0;
`endif
    e.dcyc = dcyc;
    return e;
  endfunction

  // Monitor for the SETTLE=1 instance.
  always @(negedge clk) begin
    if (!reset && done1) begin
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done1: done seen at cycle %0d with nothing expected", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("done1_cycle", cyc, e.dcyc);
        chk("maxterms1", maxterms1, e.mt);
        chk("minterms1", minterms1, e.mn);
        chk("count1", count1, e.cnt);
        chk("done1_busy", busy1, 0);
        chk("done1_xyz", {x1, y1, z1}, 0);
      end
    end
  end

  // Monitor for the SETTLE=3 instance.
  always @(negedge clk) begin
    if (!reset && done3) begin
      if (q3.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done3: done seen at cycle %0d with nothing expected", cyc);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("done3_cycle", cyc, e.dcyc);
        chk("maxterms3", maxterms3, e.mt);
        chk("minterms3", minterms3, e.mn);
        chk("count3", count3, e.cnt);
        chk("done3_busy", busy3, 0);
        chk("done3_xyz", {x3, y3, z3}, 0);
      end
    end
  end

  task automatic wait_q1();
    for (int i = 0; i < 60 && q1.size() != 0; i++) @(negedge clk);
    if (q1.size() != 0) begin
      n_checks++;
      $display("FAIL timeout1: %0d done pulses still outstanding", q1.size());
      q1.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_q3();
    for (int i = 0; i < 60 && q3.size() != 0; i++) @(negedge clk);
    if (q3.size() != 0) begin
      n_checks++;
      $display("FAIL timeout3: %0d done pulses still outstanding", q3.size());
      q3.delete();
    end
    @(negedge clk);
  endtask

  // One pulsed sweep on the SETTLE=1 instance, then check results are held.
  task automatic run1(input logic [7:0] tt, input logic [7:0] mt,
                      input logic [7:0] mn, input logic [3:0] cnt);
    @(negedge clk);
    tt1    = tt;
    start1 = 1'b1;
    q1.push_back(mk(mt, mn, cnt, cyc + 9));
    @(negedge clk);
    start1 = 1'b0;
    wait_q1();
    repeat (2) @(negedge clk);
    chk("hold_maxterms1", maxterms1, mt);
    chk("hold_minterms1", minterms1, mn);
  endtask

  initial begin
    int k;
    cyc      = 0;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    start1   = 1'b0;
    start3   = 1'b0;
    tt1      = 8'h00;
    tt3      = 8'h00;

    #3;
    chk("rst_xyz1", {x1, y1, z1}, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    chk("rst_maxterms1", maxterms1, 0);
    chk("rst_minterms1", minterms1, 0);
    chk("rst_count1", count1, 0);
    chk("rst_busy3", busy3, 0);
    chk("rst_maxterms3", maxterms3, 0);
    @(negedge clk);
    reset = 1'b0;

    // PoS(0,2,3,6,7): F=1 only at 1,4,5.
    run1(8'b0011_0010, 8'b1100_1101, 8'b0011_0010, 4'd5);
    run1(8'h00, 8'hFF, 8'h00, 4'd8);
    run1(8'hFF, 8'h00, 8'hFF, 4'd0);
    // XOR of x,y,z: F=1 at 1,2,4,7.
    run1(8'b1001_0110, 8'b0110_1001, 8'b1001_0110, 4'd4);

    // SETTLE=3: each index held 3 cycles, busy for 24 cycles.
    @(negedge clk);
    tt3    = 8'b0011_0010;
    start3 = 1'b1;
    k      = cyc;
    q3.push_back(mk(8'b1100_1101, 8'b0011_0010, 4'd5, k + 25));
    @(negedge clk);
    start3 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      chk("busy3_sweep", busy3, 1);
      chk("xyz3_sweep", {x3, y3, z3}, i / 3);
      @(negedge clk);
    end
    chk("busy3_end", busy3, 0);
    chk("done3_at_end", done3, 1);
    wait_q3();

    // Start pulses while busy and while in DONE are ignored.
    @(negedge clk);
    tt1    = 8'b1111_0000;
    start1 = 1'b1;
    k      = cyc;
    q1.push_back(mk(8'b0000_1111, 8'b1111_0000, 4'd4, k + 9));
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      start1 = (j == 3 || j == 9);
    end
    start1 = 1'b0;
    wait_q1();
    repeat (12) @(negedge clk);

    // start held for 30 cycles: three sweeps, each separated by one IDLE cycle.
    @(negedge clk);
    tt1    = 8'b1001_0110;
    start1 = 1'b1;
    k      = cyc;
    q1.push_back(mk(8'b0110_1001, 8'b1001_0110, 4'd4, k + 9));
    q1.push_back(mk(8'b0110_1001, 8'b1001_0110, 4'd4, k + 19));
    q1.push_back(mk(8'b0110_1001, 8'b1001_0110, 4'd4, k + 29));
    repeat (30) @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    wait_q1();

    // Reset mid-sweep at index 100 after a completed sweep.
    run1(8'b0011_0010, 8'b1100_1101, 8'b0011_0010, 4'd5);
    @(negedge clk);
    tt1    = 8'b1111_0000;
    start1 = 1'b1;
    q1.push_back(mk(8'b0000_1111, 8'b1111_0000, 4'd4, cyc + 9));
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 20 && {x1, y1, z1} != 3'b100; i++) @(negedge clk);
    chk("xyz1_reached_100", {x1, y1, z1}, 3'b100);
    chk("midsweep_hold_maxterms1", maxterms1, 8'b1100_1101);
    #2;
    reset = 1'b1;
    #1;
    q1.delete();
    chk("arst_xyz1", {x1, y1, z1}, 0);
    chk("arst_busy1", busy1, 0);
    chk("arst_done1", done1, 0);
    chk("arst_maxterms1", maxterms1, 0);
    chk("arst_minterms1", minterms1, 0);
    chk("arst_count1", count1, 0);
    chk("arst_maxterms3", maxterms3, 0);
    chk("arst_minterms3", minterms3, 0);
    repeat (2) @(negedge clk);
    chk("arst_hold_done1", done1, 0);
    reset  = 1'b0;
    start1 = 1'b1;
    q1.push_back(mk(8'b0000_1111, 8'b1111_0000, 4'd4, cyc + 9));
    @(negedge clk);
    start1 = 1'b0;
    chk("first_start_busy1", busy1, 1);
    wait_q1();
    chk("post_rst_maxterms1", maxterms1, 8'b0000_1111);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
